// File: rtl/bp_tournament_pred_if.sv
// Fetch-side lookup and EX-side training signals of the tournament branch predictor.
// The master drives fetch/resolution inputs; the predictor uses the slave modport.
interface bp_tournament_pred_if #(
    parameter int IDX_W = 8
);
    logic             if1_req;
    logic [31:0]      if1_pc;
    logic             if2_wen;
    logic             flush;
    logic             if2_answ_bht;
    logic             if2_answ_ghr;
    logic             if2_branch_bp;
    logic [IDX_W-1:0] if2_pht_idx;
    logic             ex_upd_valid;
    logic [31:0]      ex_upd_pc;
    logic [IDX_W-1:0] ex_upd_pht_idx;
    logic             ex_upd_taken;
    logic             ex_answ_bht;
    logic             ex_answ_ghr;

    modport master (
        output if1_req, if1_pc, if2_wen, flush,
        output ex_upd_valid, ex_upd_pc, ex_upd_pht_idx, ex_upd_taken, ex_answ_bht, ex_answ_ghr,
        input  if2_answ_bht, if2_answ_ghr, if2_branch_bp, if2_pht_idx
    );

    modport slave (
        input  if1_req, if1_pc, if2_wen, flush,
        input  ex_upd_valid, ex_upd_pc, ex_upd_pht_idx, ex_upd_taken, ex_answ_bht, ex_answ_ghr,
        output if2_answ_bht, if2_answ_ghr, if2_branch_bp, if2_pht_idx
    );
endinterface

// File: rtl/bp_tournament_pred.sv
// Tournament predictor: local BHT, gshare PHT and a chooser table, looked up in IF1 and
// registered into IF2; trained non-speculatively from EX resolutions.
module bp_tournament_pred #(
    parameter int IDX_W = 8,
    parameter int GHR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    bp_tournament_pred_if.slave bus
);
    localparam int N = 1 << IDX_W;

    logic [1:0]       bht_reg  [N];
    logic [1:0]       pht_reg  [N];
    logic [1:0]       cht_reg  [N];
    logic [1:0]       bht_next [N];
    logic [1:0]       pht_next [N];
    logic [1:0]       cht_next [N];
    logic [GHR_W-1:0] ghr_reg;
    logic [GHR_W-1:0] ghr_next;

    logic             answ_bht_reg;
    logic             answ_ghr_reg;
    logic             branch_bp_reg;
    logic [IDX_W-1:0] pht_idx_reg;

    logic [IDX_W-1:0] lk_bht_idx;
    logic [IDX_W-1:0] lk_pht_idx;
    logic [IDX_W-1:0] up_bht_idx;
    logic             lk_answ_bht;
    logic             lk_answ_ghr;
    logic             cht_train;
    logic             cht_up;
    logic             unused_pc_bits;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up)
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

    // Lookup uses the committed GHR; same-cycle training is not bypassed.
    assign lk_bht_idx  = bus.if1_pc[IDX_W+1:2];
    assign lk_pht_idx  = lk_bht_idx ^ IDX_W'(ghr_reg);
    assign up_bht_idx  = bus.ex_upd_pc[IDX_W+1:2];
    assign lk_answ_bht = bht_reg[lk_bht_idx][1];
    assign lk_answ_ghr = pht_reg[lk_pht_idx][1];

    // Chooser only learns when the two components disagreed.
    assign cht_train = bus.ex_upd_valid && (bus.ex_answ_bht != bus.ex_answ_ghr);
    assign cht_up    = (bus.ex_answ_ghr == bus.ex_upd_taken);

    assign unused_pc_bits = ^{bus.if1_pc[31:IDX_W+2], bus.if1_pc[1:0],
                              bus.ex_upd_pc[31:IDX_W+2], bus.ex_upd_pc[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            assign bht_next[gi] = (bus.ex_upd_valid && up_bht_idx == IDX_W'(gi))
                                  ? sat_step(bht_reg[gi], bus.ex_upd_taken) : bht_reg[gi];
            assign pht_next[gi] = (bus.ex_upd_valid && bus.ex_upd_pht_idx == IDX_W'(gi))
                                  ? sat_step(pht_reg[gi], bus.ex_upd_taken) : pht_reg[gi];
            assign cht_next[gi] = (cht_train && up_bht_idx == IDX_W'(gi))
                                  ? sat_step(cht_reg[gi], cht_up) : cht_reg[gi];
        end

        if (GHR_W == 1) begin : g_ghr1
            assign ghr_next = bus.ex_upd_taken;
        end else begin : g_ghrn
            assign ghr_next = {ghr_reg[GHR_W-2:0], bus.ex_upd_taken};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                bht_reg[i] <= 2'b01;
                pht_reg[i] <= 2'b01;
                cht_reg[i] <= 2'b01;
            end
            ghr_reg <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                bht_reg[i] <= bht_next[i];
                pht_reg[i] <= pht_next[i];
                cht_reg[i] <= cht_next[i];
            end
            if (bus.ex_upd_valid)
                ghr_reg <= ghr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            answ_bht_reg  <= 1'b0;
            answ_ghr_reg  <= 1'b0;
            branch_bp_reg <= 1'b0;
            pht_idx_reg   <= '0;
        end else if (bus.if2_wen) begin
            if (bus.if1_req) begin
                answ_bht_reg  <= lk_answ_bht;
                answ_ghr_reg  <= lk_answ_ghr;
                branch_bp_reg <= cht_reg[lk_bht_idx][1] ? lk_answ_ghr : lk_answ_bht;
                pht_idx_reg   <= lk_pht_idx;
            end else begin
                answ_bht_reg  <= 1'b0;
                answ_ghr_reg  <= 1'b0;
                branch_bp_reg <= 1'b0;
                pht_idx_reg   <= '0;
            end
        end
    end

    assign bus.if2_answ_bht  = answ_bht_reg;
    assign bus.if2_answ_ghr  = answ_ghr_reg;
    assign bus.if2_branch_bp = branch_bp_reg;
    assign bus.if2_pht_idx   = pht_idx_reg;
endmodule

// File: tb/tb_bp_tournament_pred.sv
// Directed-vector bench for bp_tournament_pred: each vector is one clock of stimulus and
// the IF2 outputs expected right after that edge.
module tb_bp_tournament_pred;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bp_tournament_pred_if #(.IDX_W(8)) bus ();

    bp_tournament_pred #(.IDX_W(8), .GHR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        wen;
        logic        flush;
        logic        uv;
        logic [31:0] upc;
        logic [7:0]  uidx;
        logic        tk;
        logic        ab;
        logic        ag;
        logic        e_bht;
        logic        e_ghr;
        logic        e_bp;
        logic [7:0]  e_idx;
    } vec_t;

    function automatic vec_t mk(input logic req, input logic [31:0] pc, input logic wen,
                                input logic flush, input logic uv, input logic [31:0] upc,
                                input logic [7:0] uidx, input logic tk, input logic ab,
                                input logic ag, input logic e_bht, input logic e_ghr,
                                input logic e_bp, input logic [7:0] e_idx);
        vec_t v;
        v.req = req; v.pc = pc; v.wen = wen; v.flush = flush;
        v.uv = uv; v.upc = upc; v.uidx = uidx; v.tk = tk; v.ab = ab; v.ag = ag;
        v.e_bht = e_bht; v.e_ghr = e_ghr; v.e_bp = e_bp; v.e_idx = e_idx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.if1_req        = v.req;
        bus.if1_pc         = v.pc;
        bus.if2_wen        = v.wen;
        bus.flush          = v.flush;
        bus.ex_upd_valid   = v.uv;
        bus.ex_upd_pc      = v.upc;
        bus.ex_upd_pht_idx = v.uidx;
        bus.ex_upd_taken   = v.tk;
        bus.ex_answ_bht    = v.ab;
        bus.ex_answ_ghr    = v.ag;
    endtask

    task automatic check_out(input string tag, input logic e_bht, input logic e_ghr,
                             input logic e_bp, input logic [7:0] e_idx);
        $display("%s: bht=%0d ghr=%0d bp=%0d idx=%02h (want %0d %0d %0d %02h)", tag,
                 bus.if2_answ_bht, bus.if2_answ_ghr, bus.if2_branch_bp, bus.if2_pht_idx,
                 e_bht, e_ghr, e_bp, e_idx);
        chk({tag, ".answ_bht"},  32'(bus.if2_answ_bht),  32'(e_bht));
        chk({tag, ".answ_ghr"},  32'(bus.if2_answ_ghr),  32'(e_ghr));
        chk({tag, ".branch_bp"}, 32'(bus.if2_branch_bp), 32'(e_bp));
        chk({tag, ".pht_idx"},   32'(bus.if2_pht_idx),   32'(e_idx));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check_out(tag, v.e_bht, v.e_ghr, v.e_bp, v.e_idx);
    endtask

    vec_t tbl [13];
    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
        // Counter training, GHR formation and saturation at entry 4.
        tbl[0]  = mk(1, 32'h1c000000, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[1]  = mk(0, 0, 1, 0, 1, 32'h1c000010, 8'h04, 1, 0, 0, 0, 0, 0, 8'h00);
        tbl[2]  = mk(0, 0, 1, 0, 1, 32'h1c000010, 8'h04, 1, 0, 0, 0, 0, 0, 8'h00);
        tbl[3]  = mk(1, 32'h1c000010, 1, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h07);
        tbl[4]  = mk(1, 32'h1c000010, 1, 0, 1, 32'h1c000010, 8'h04, 1, 0, 0, 1, 0, 1, 8'h07);
        tbl[5]  = mk(1, 32'h1c000010, 1, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h03);
        tbl[6]  = mk(1, 32'h1c00000c, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h04);
        // Chooser toward gshare at entry 8, then BHT[8] pulled back to 01 with equal answers.
        tbl[7]  = mk(0, 0, 1, 0, 1, 32'h1c000020, 8'hf4, 1, 0, 1, 0, 0, 0, 8'h00);
        tbl[8]  = mk(0, 0, 1, 0, 1, 32'h1c000020, 8'hf4, 1, 0, 1, 0, 0, 0, 8'h00);
        tbl[9]  = mk(0, 0, 1, 0, 1, 32'h1c000020, 8'hf4, 1, 0, 1, 0, 0, 0, 8'h00);
        tbl[10] = mk(0, 0, 1, 0, 1, 32'h1c000020, 8'h55, 0, 1, 1, 0, 0, 0, 8'h00);
        tbl[11] = mk(0, 0, 1, 0, 1, 32'h1c000020, 8'h55, 0, 1, 1, 0, 0, 0, 8'h00);
        tbl[12] = mk(1, 32'h1c000020, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 8'hf4);

        drive(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Stall: held taken prediction survives pc changes and training on its entry.
        run_vec(mk(1, 32'h1c000010, 0, 0, 1, 32'h1c000020, 8'hf4, 0, 0, 1, 0, 1, 1, 8'hf4), "stall1");
        run_vec(mk(1, 32'h1c000000, 0, 0, 1, 32'h1c000020, 8'hf4, 0, 0, 1, 0, 1, 1, 8'hf4), "stall2");
        run_vec(mk(1, 32'h1c00000c, 0, 0, 1, 32'h1c000020, 8'hf4, 0, 0, 1, 0, 1, 1, 8'hf4), "stall3");
        run_vec(mk(1, 32'h1c000020, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'he8), "stall_rel");

        // Flush while stalled clears outputs; the concurrent update still shifts GHR.
        run_vec(mk(1, 32'h1c000010, 1, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 8'he4), "flush_ld");
        run_vec(mk(1, 32'h1c000010, 0, 1, 1, 32'h1c000040, 8'h20, 1, 0, 0, 0, 0, 0, 8'h00), "flush");
        run_vec(mk(1, 32'h1c000000, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hc1), "flush_ghr");

        // Same-cycle lookup and update of BHT[0x0c]: no bypass, then visible.
        run_vec(mk(1, 32'h1c000030, 1, 0, 1, 32'h1c000030, 8'h33, 1, 0, 0, 0, 0, 0, 8'hcd), "rw_same");
        run_vec(mk(1, 32'h1c000030, 1, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h8f), "rw_after");
        run_vec(mk(0, 32'h1c000030, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00), "bubble");

        // Reset asserted alongside a training update wipes everything.
        @(negedge clk);
        drive(mk(1, 32'h1c000010, 1, 0, 1, 32'h1c000010, 8'h04, 1, 0, 1, 0, 0, 0, 8'h00));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_out("rst_upd", 0, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle);
        run_vec(mk(1, 32'h1c000010, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h04), "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
